vx_dcache_sched: RTL and testbench
==================================

Name: vx_dcache_sched

Overview:
- Schedules NUM_REQS execute-stage requesters (LSU, TEX, future units) onto the single dcache request/response port.
- Round-robin grant, registered output stage, per-requester outstanding-read credit limit.
- Requester index is appended to the tag so responses route back by tag.
- Sits between functional units and the core dcache interface.

Parameters:
- NUM_REQS, 2: number of requesters (2..8).
- LANES, 4: lanes per request (equals NUM_THREADS).
- DATA_SIZE, 4: bytes per lane word.
- ADDR_WIDTH, 30: word address bits per lane.
- TAG_IN_WIDTH, 8: requester tag bits.
- MAX_PENDING, 16: max outstanding reads per requester (power of 2).
- Derived: SEL_BITS = max(1, clog2(NUM_REQS)); TAG_OUT_WIDTH = TAG_IN_WIDTH + SEL_BITS.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid_in  in  NUM_REQS  request valid per requester
- req_rw_in  in  NUM_REQS  1 = write, 0 = read
- req_tmask_in  in  NUM_REQS*LANES  lane mask
- req_byteen_in  in  NUM_REQS*LANES*DATA_SIZE  byte enables
- req_addr_in  in  NUM_REQS*LANES*ADDR_WIDTH  lane addresses
- req_data_in  in  NUM_REQS*LANES*DATA_SIZE*8  write data
- req_tag_in  in  NUM_REQS*TAG_IN_WIDTH  tags
- req_ready_in  out  NUM_REQS  accept per requester
- req_valid_out, req_rw_out, req_tmask_out, req_byteen_out, req_addr_out, req_data_out  out  (single-requester widths)  dcache request
- req_tag_out  out  TAG_OUT_WIDTH  {req_tag, sel}; sel occupies the LSBs
- req_ready_out  in  1  dcache accept
- rsp_valid_in  in  1  dcache response valid
- rsp_tmask_in  in  LANES  response lane mask
- rsp_data_in  in  LANES*DATA_SIZE*8  response data
- rsp_tag_in  in  TAG_OUT_WIDTH  response tag
- rsp_ready_in  out  1  response accept
- rsp_valid_out  out  NUM_REQS  routed response valid
- rsp_tmask_out, rsp_data_out, rsp_tag_out  out  LANES, LANES*DATA_SIZE*8, TAG_IN_WIDTH  broadcast to all requesters
- rsp_ready_out  in  NUM_REQS  requester response accept
- sel_err  out  1  one-cycle pulse on an out-of-range response sel

Behaviour:
- Reset: req_valid_out=0, rr pointer=0, all pending counters=0, sel_err=0, all ready outputs 0 during reset.
- Eligibility: eligible[i] = req_valid_in[i] && (req_rw_in[i] || pend[i] < MAX_PENDING).
- Grant: round-robin over eligible[], starting at pointer.
  - Pointer moves to grant+1 (mod NUM_REQS) only when the grant fires.
  - Pointer holds if the grant does not fire.
- Output stage: one-entry register, latency 1.
  - stage_ready = !req_valid_out || req_ready_out.
  - req_ready_in[g] = eligible[g] && stage_ready; all other req_ready_in = 0.
  - On fire, the register loads requester g's fields and tag {tag, g[SEL_BITS-1:0]}.
  - Registered payload holds stable while req_valid_out && !req_ready_out.
  - Back-to-back throughput: 1 request/cycle.
- Pending counters: clog2(MAX_PENDING)+1 bits.
  - Increment on an accepted read from i; decrement on response fire to i.
  - Same-cycle increment and decrement: counter unchanged.
  - Decrement at 0 has no effect.
- Response path: fully combinational.
  - sel = rsp_tag_in LSBs.
  - rsp_valid_out[sel] = rsp_valid_in; rsp_tag_out = upper TAG_IN_WIDTH bits; rsp_ready_in = rsp_ready_out[sel].
  - sel >= NUM_REQS: rsp_ready_in=1, no rsp_valid_out, sel_err pulses the next cycle.
- Writes never consume credit and never generate responses.
- Reset mid-transfer drops the registered request and clears credits; in-flight responses are the dcache's responsibility to flush.

Optional Feature:
- Macro: DCACHE_SCHED_PERF_EN.
- Defined: adds output port perf_stall_cycles, NUM_REQS*32 bits.
  - Per requester, counts cycles with req_valid_in[i] && !req_ready_in[i].
  - Saturates at 2^32-1; cleared by reset.
- Undefined: port and counters absent; behaviour otherwise identical.

Decomposition:
- Package vx_dcache_sched_pkg: SEL_BITS/TAG_OUT_WIDTH helper functions, pending-counter width constant, requester index constants LSU_REQ_IDX=0 and TEX_REQ_IDX=1.
- One sub-module vx_rr_arbiter (parameter N):
  - Inputs: requests, advance.
  - Outputs: one-hot grant, grant index, valid.
  - Owns the pointer.

Test Plan:
- Requesters 0 and 1 valid continuously, ready_out=1 -> output sel alternates 0,1,0,1; each ready_in high every other cycle.
- Requester 0 issues 16 reads, no responses -> pend[0]=16, req_ready_in[0]=0; a write from 0 is still accepted; one response with sel=0 -> the next read is accepted the following cycle.
- req_ready_out=0 for 3 cycles with a registered request -> req_*_out stable, all req_ready_in=0; release -> request delivered once.
- Response tag {8'hA5, 1'b1} with rsp_ready_out=2'b10 -> rsp_valid_out=2'b10, rsp_tag_out=8'hA5, rsp_ready_in=1; pend[1] decrements.
- NUM_REQS=3, response sel=3 -> rsp_ready_in=1, rsp_valid_out=0, sel_err pulses one cycle.
- Assert reset while req_valid_out=1 with pend=5 -> next cycle req_valid_out=0, pend=0, pointer=0.

Source files
------------

// File: rtl/vx_dcache_sched_pkg.sv
// Shared constants and width helpers for the dcache request scheduler.
package vx_dcache_sched_pkg;

  localparam int unsigned LSU_REQ_IDX = 0;
  localparam int unsigned TEX_REQ_IDX = 1;

  // Requester select field is at least one bit, even for a single requester.
  function automatic int unsigned calc_sel_bits(input int unsigned num_reqs);
    return (num_reqs > 1) ? $clog2(num_reqs) : 1;
  endfunction

  function automatic int unsigned calc_tag_out_width(input int unsigned tag_in_width,
                                                     input int unsigned num_reqs);
    return tag_in_width + calc_sel_bits(num_reqs);
  endfunction

  // One extra bit so a counter can hold MAX_PENDING itself.
  function automatic int unsigned calc_pend_width(input int unsigned max_pending);
    return $clog2(max_pending) + 1;
  endfunction

endpackage

// File: rtl/vx_dcache_sched_rr_arbiter.sv
// Round-robin arbiter; search starts at the pointer, which moves past the
// granted requester only when the grant is consumed.
module vx_rr_arbiter
  import vx_dcache_sched_pkg::*;
#(
  parameter int unsigned N = 2,
  localparam int unsigned IDX_W = calc_sel_bits(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     requests,
  input  logic             advance,
  output logic [N-1:0]     grant_onehot,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant_valid  = 1'b0;
    grant_idx    = '0;
    cand         = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IDX_W'((32'(ptr) + k) % N);
      if (!grant_valid && requests[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
    grant_onehot = grant_valid ? (N'(1) << grant_idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance && grant_valid) begin
      ptr <= (32'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/vx_dcache_sched.sv
// Schedules NUM_REQS requesters onto one dcache port with per-requester read
// credits. Optional stall counters: define DCACHE_SCHED_PERF_EN.
module vx_dcache_sched
  import vx_dcache_sched_pkg::*;
#(
  parameter int unsigned NUM_REQS     = 2,
  parameter int unsigned LANES        = 4,
  parameter int unsigned DATA_SIZE    = 4,
  parameter int unsigned ADDR_WIDTH   = 30,
  parameter int unsigned TAG_IN_WIDTH = 8,
  parameter int unsigned MAX_PENDING  = 16,
  localparam int unsigned SEL_BITS      = calc_sel_bits(NUM_REQS),
  localparam int unsigned TAG_OUT_WIDTH = calc_tag_out_width(TAG_IN_WIDTH, NUM_REQS),
  localparam int unsigned WORD_W        = DATA_SIZE * 8
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [NUM_REQS-1:0]                       req_valid_in,
  input  logic [NUM_REQS-1:0]                       req_rw_in,
  input  logic [NUM_REQS*LANES-1:0]                 req_tmask_in,
  input  logic [NUM_REQS*LANES*DATA_SIZE-1:0]       req_byteen_in,
  input  logic [NUM_REQS*LANES*ADDR_WIDTH-1:0]      req_addr_in,
  input  logic [NUM_REQS*LANES*WORD_W-1:0]          req_data_in,
  input  logic [NUM_REQS*TAG_IN_WIDTH-1:0]          req_tag_in,
  output logic [NUM_REQS-1:0]                       req_ready_in,
  output logic                                      req_valid_out,
  output logic                                      req_rw_out,
  output logic [LANES-1:0]                          req_tmask_out,
  output logic [LANES*DATA_SIZE-1:0]                req_byteen_out,
  output logic [LANES*ADDR_WIDTH-1:0]               req_addr_out,
  output logic [LANES*WORD_W-1:0]                   req_data_out,
  output logic [TAG_OUT_WIDTH-1:0]                  req_tag_out,
  input  logic                                      req_ready_out,
  input  logic                                      rsp_valid_in,
  input  logic [LANES-1:0]                          rsp_tmask_in,
  input  logic [LANES*WORD_W-1:0]                   rsp_data_in,
  input  logic [TAG_OUT_WIDTH-1:0]                  rsp_tag_in,
  output logic                                      rsp_ready_in,
  output logic [NUM_REQS-1:0]                       rsp_valid_out,
  output logic [LANES-1:0]                          rsp_tmask_out,
  output logic [LANES*WORD_W-1:0]                   rsp_data_out,
  output logic [TAG_IN_WIDTH-1:0]                   rsp_tag_out,
  input  logic [NUM_REQS-1:0]                       rsp_ready_out,
`ifdef DCACHE_SCHED_PERF_EN
  output logic [NUM_REQS*32-1:0]                    perf_stall_cycles,
`endif
  output logic                                      sel_err
);

  localparam int unsigned PEND_WIDTH = calc_pend_width(MAX_PENDING);

  logic [PEND_WIDTH-1:0]      pend [NUM_REQS];
  logic [NUM_REQS-1:0]        eligible;
  logic [NUM_REQS-1:0]        arb_onehot;
  logic [SEL_BITS-1:0]        arb_idx;
  logic                       arb_valid;
  logic                       stage_ready;
  logic                       req_fire;
  logic [NUM_REQS-1:0]        pend_inc;
  logic [NUM_REQS-1:0]        pend_dec;
  logic [SEL_BITS-1:0]        rsp_sel;
  logic                       sel_ok;
  logic                       sel_ready;

  logic                       mux_rw;
  logic [LANES-1:0]           mux_tmask;
  logic [LANES*DATA_SIZE-1:0] mux_byteen;
  logic [LANES*ADDR_WIDTH-1:0] mux_addr;
  logic [LANES*WORD_W-1:0]    mux_data;
  logic [TAG_IN_WIDTH-1:0]    mux_tag;

  // Reads are blocked once a requester has MAX_PENDING responses outstanding.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      eligible[i] = req_valid_in[i] && (req_rw_in[i] || (pend[i] < PEND_WIDTH'(MAX_PENDING)));
    end
  end

  vx_rr_arbiter #(
    .N (NUM_REQS)
  ) u_arb (
    .clk          (clk),
    .reset        (reset),
    .requests     (eligible),
    .advance      (req_fire),
    .grant_onehot (arb_onehot),
    .grant_idx    (arb_idx),
    .grant_valid  (arb_valid)
  );

  always_comb begin
    stage_ready  = !req_valid_out || req_ready_out;
    req_fire     = arb_valid && stage_ready && !reset;
    req_ready_in = req_fire ? arb_onehot : '0;
    pend_inc     = req_ready_in & ~req_rw_in;
  end

  always_comb begin
    mux_rw     = 1'b0;
    mux_tmask  = '0;
    mux_byteen = '0;
    mux_addr   = '0;
    mux_data   = '0;
    mux_tag    = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (arb_onehot[i]) begin
        mux_rw     = req_rw_in[i];
        mux_tmask  = req_tmask_in[i*LANES +: LANES];
        mux_byteen = req_byteen_in[i*LANES*DATA_SIZE +: LANES*DATA_SIZE];
        mux_addr   = req_addr_in[i*LANES*ADDR_WIDTH +: LANES*ADDR_WIDTH];
        mux_data   = req_data_in[i*LANES*WORD_W +: LANES*WORD_W];
        mux_tag    = req_tag_in[i*TAG_IN_WIDTH +: TAG_IN_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_valid_out <= 1'b0;
      sel_err       <= 1'b0;
    end else begin
      if (stage_ready) begin
        req_valid_out <= req_fire;
      end
      sel_err <= rsp_valid_in && !sel_ok;
    end
  end

  // Payload only moves on a fire, so it is stable while the dcache stalls.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      req_rw_out     <= mux_rw;
      req_tmask_out  <= mux_tmask;
      req_byteen_out <= mux_byteen;
      req_addr_out   <= mux_addr;
      req_data_out   <= mux_data;
      req_tag_out    <= {mux_tag, arb_idx};
    end
  end

  // Out-of-range selects are drained so a bad tag cannot wedge the dcache.
  always_comb begin
    rsp_sel       = rsp_tag_in[SEL_BITS-1:0];
    sel_ok        = 32'(rsp_sel) < NUM_REQS;
    sel_ready     = 1'b0;
    rsp_valid_out = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (rsp_sel == SEL_BITS'(i)) begin
        sel_ready        = rsp_ready_out[i];
        rsp_valid_out[i] = rsp_valid_in;
      end
    end
    rsp_ready_in = !reset && (sel_ok ? sel_ready : 1'b1);
    pend_dec     = rsp_ready_in ? rsp_valid_out : '0;
  end

  assign rsp_tmask_out = rsp_tmask_in;
  assign rsp_data_out  = rsp_data_in;
  assign rsp_tag_out   = rsp_tag_in[TAG_OUT_WIDTH-1:SEL_BITS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        pend[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (pend_inc[i] && !pend_dec[i]) begin
          pend[i] <= pend[i] + 1'b1;
        end else if (!pend_inc[i] && pend_dec[i] && (pend[i] != '0)) begin
          pend[i] <= pend[i] - 1'b1;
        end
      end
    end
  end

`ifdef DCACHE_SCHED_PERF_EN
  logic [31:0] stall_cnt [NUM_REQS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        stall_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (req_valid_in[i] && !req_ready_in[i] && (stall_cnt[i] != '1)) begin
          stall_cnt[i] <= stall_cnt[i] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    perf_stall_cycles = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      perf_stall_cycles[i*32 +: 32] = stall_cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_vx_dcache_sched.sv
// Directed plus randomized bench for vx_dcache_sched against a behavioural model.
module tb_vx_dcache_sched;
  import vx_dcache_sched_pkg::*;

  localparam int N   = 3;
  localparam int L   = 4;
  localparam int DS  = 4;
  localparam int AW  = 30;
  localparam int TW  = 8;
  localparam int MP  = 16;
  localparam int SB  = 2;
  localparam int TOW = TW + SB;
  localparam int DW  = L * DS * 8;

  logic                clk = 1'b0;
  logic                reset;
  logic [N-1:0]        req_valid_in, req_rw_in, req_ready_in;
  logic [N*L-1:0]      req_tmask_in;
  logic [N*L*DS-1:0]   req_byteen_in;
  logic [N*L*AW-1:0]   req_addr_in;
  logic [N*DW-1:0]     req_data_in;
  logic [N*TW-1:0]     req_tag_in;
  logic                req_valid_out, req_rw_out, req_ready_out;
  logic [L-1:0]        req_tmask_out;
  logic [L*DS-1:0]     req_byteen_out;
  logic [L*AW-1:0]     req_addr_out;
  logic [DW-1:0]       req_data_out;
  logic [TOW-1:0]      req_tag_out;
  logic                rsp_valid_in, rsp_ready_in;
  logic [L-1:0]        rsp_tmask_in, rsp_tmask_out;
  logic [DW-1:0]       rsp_data_in, rsp_data_out;
  logic [TOW-1:0]      rsp_tag_in;
  logic [N-1:0]        rsp_valid_out, rsp_ready_out;
  logic [TW-1:0]       rsp_tag_out;
  logic                sel_err;

  vx_dcache_sched #(
    .NUM_REQS(N), .LANES(L), .DATA_SIZE(DS), .ADDR_WIDTH(AW),
    .TAG_IN_WIDTH(TW), .MAX_PENDING(MP)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid_in(req_valid_in), .req_rw_in(req_rw_in), .req_tmask_in(req_tmask_in),
    .req_byteen_in(req_byteen_in), .req_addr_in(req_addr_in), .req_data_in(req_data_in),
    .req_tag_in(req_tag_in), .req_ready_in(req_ready_in),
    .req_valid_out(req_valid_out), .req_rw_out(req_rw_out), .req_tmask_out(req_tmask_out),
    .req_byteen_out(req_byteen_out), .req_addr_out(req_addr_out), .req_data_out(req_data_out),
    .req_tag_out(req_tag_out), .req_ready_out(req_ready_out),
    .rsp_valid_in(rsp_valid_in), .rsp_tmask_in(rsp_tmask_in), .rsp_data_in(rsp_data_in),
    .rsp_tag_in(rsp_tag_in), .rsp_ready_in(rsp_ready_in),
    .rsp_valid_out(rsp_valid_out), .rsp_tmask_out(rsp_tmask_out), .rsp_data_out(rsp_data_out),
    .rsp_tag_out(rsp_tag_out), .rsp_ready_out(rsp_ready_out),
    .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: round-robin start, outstanding reads, one buffered request.
  int               m_ptr;
  int               m_pend [N];
  bit               m_vld, m_serr;
  logic             m_rw;
  logic [L-1:0]     m_tmask;
  logic [L*DS-1:0]  m_byteen;
  logic [L*AW-1:0]  m_addr;
  logic [DW-1:0]    m_data;
  logic [TOW-1:0]   m_tag;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int w = 0; w < 16; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic rand_payload();
    logic [511:0] r;
    r = rnd512(); req_addr_in   = r[N*L*AW-1:0];
    r = rnd512(); req_data_in   = r[N*DW-1:0];
    r = rnd512(); req_tmask_in  = r[N*L-1:0];
    req_byteen_in = r[100 +: N*L*DS];
    req_tag_in    = r[200 +: N*TW];
    r = rnd512(); rsp_data_in = r[DW-1:0];
    rsp_tmask_in  = r[300 +: L];
  endtask

  task automatic idle();
    reset = 1'b0; req_valid_in = '0; req_rw_in = '0; req_ready_out = 1'b1;
    rsp_valid_in = 1'b0; rsp_tag_in = '0; rsp_ready_out = '1;
    rand_payload();
  endtask

  // One clock: check combinational outputs, step the model, check registered outputs.
  task automatic cycle();
    int g, sel;
    bit sr, fire, inr, rri, rfire;
    logic [N-1:0] exp_rdy, exp_rv;
    #1;
    sr = !m_vld || req_ready_out;
    g = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (g < 0 && req_valid_in[j] && (req_rw_in[j] || m_pend[j] < MP)) g = j;
    end
    fire = (g >= 0) && sr && !reset;
    exp_rdy = '0;
    if (fire) exp_rdy[g] = 1'b1;
    sel = int'(rsp_tag_in[SB-1:0]);
    inr = sel < N;
    exp_rv = '0;
    rri = 1'b1;
    if (inr) begin
      rri = rsp_ready_out[sel];
      if (rsp_valid_in) exp_rv[sel] = 1'b1;
    end
    if (reset) rri = 1'b0;
    rfire = rsp_valid_in && rri && inr;
    check("req_ready_in", 512'(req_ready_in), 512'(exp_rdy));
    check("rsp_valid_out", 512'(rsp_valid_out), 512'(exp_rv));
    check("rsp_ready_in", 512'(rsp_ready_in), 512'(rri));
    check("rsp_tag_out", 512'(rsp_tag_out), 512'(rsp_tag_in[TOW-1:SB]));
    check("rsp_data_out", 512'(rsp_data_out), 512'(rsp_data_in));
    check("rsp_tmask_out", 512'(rsp_tmask_out), 512'(rsp_tmask_in));
    @(posedge clk);
    if (reset) begin
      m_vld = 1'b0; m_ptr = 0; m_serr = 1'b0;
      for (int i = 0; i < N; i++) m_pend[i] = 0;
    end else begin
      if (sr) m_vld = fire;
      if (fire) begin
        m_rw     = req_rw_in[g];
        m_tmask  = req_tmask_in[g*L +: L];
        m_byteen = req_byteen_in[g*L*DS +: L*DS];
        m_addr   = req_addr_in[g*L*AW +: L*AW];
        m_data   = req_data_in[g*DW +: DW];
        m_tag    = {req_tag_in[g*TW +: TW], SB'(g)};
        m_ptr    = (g + 1) % N;
        if (!req_rw_in[g]) m_pend[g]++;
      end
      if (rfire && m_pend[sel] > 0) m_pend[sel]--;
      m_serr = rsp_valid_in && !inr;
    end
    @(negedge clk);
    check("req_valid_out", 512'(req_valid_out), 512'(m_vld));
    check("sel_err", 512'(sel_err), 512'(m_serr));
    if (m_vld) begin
      check("req_rw_out", 512'(req_rw_out), 512'(m_rw));
      check("req_tmask_out", 512'(req_tmask_out), 512'(m_tmask));
      check("req_byteen_out", 512'(req_byteen_out), 512'(m_byteen));
      check("req_addr_out", 512'(req_addr_out), 512'(m_addr));
      check("req_data_out", 512'(req_data_out), 512'(m_data));
      check("req_tag_out", 512'(req_tag_out), 512'(m_tag));
    end
  endtask

  task automatic read_burst(input int idx, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      idle();
      req_valid_in[idx] = 1'b1;
      cycle();
    end
  endtask

  initial begin
    m_ptr = 0; m_vld = 1'b0; m_serr = 1'b0;
    for (int i = 0; i < N; i++) m_pend[i] = 0;

    // Reset with live requests: no ready may assert.
    idle(); reset = 1'b1; req_valid_in = '1;
    cycle(); cycle();
    idle(); cycle();

    // Two continuous writers alternate.
    for (int k = 0; k < 8; k++) begin
      idle(); req_valid_in = 3'b011; req_rw_in = 3'b011;
      cycle();
      check("alt_sel", 512'(req_tag_out[SB-1:0]), 512'(k % 2));
    end

    // Credit limit on requester 0.
    read_burst(LSU_REQ_IDX, 16);
    idle(); req_valid_in[LSU_REQ_IDX] = 1'b1; #1;
    check("credit_full", 512'(req_ready_in[LSU_REQ_IDX]), 512'(0));
    cycle();
    idle(); req_valid_in[LSU_REQ_IDX] = 1'b1; req_rw_in[LSU_REQ_IDX] = 1'b1; #1;
    check("write_no_credit", 512'(req_ready_in[LSU_REQ_IDX]), 512'(1));
    cycle();
    idle(); req_valid_in[LSU_REQ_IDX] = 1'b1;
    rsp_valid_in = 1'b1; rsp_tag_in = {8'h3C, 2'd0}; rsp_ready_out = 3'b001; #1;
    check("credit_same_cycle", 512'(req_ready_in[LSU_REQ_IDX]), 512'(0));
    cycle();
    idle(); req_valid_in[LSU_REQ_IDX] = 1'b1; #1;
    check("credit_returned", 512'(req_ready_in[LSU_REQ_IDX]), 512'(1));
    cycle();

    // Output stall: payload held, nothing accepted, then a single delivery.
    idle(); req_valid_in = 3'b011; req_rw_in = 3'b011; cycle();
    for (int k = 0; k < 3; k++) begin
      idle(); req_valid_in = 3'b011; req_rw_in = 3'b011; req_ready_out = 1'b0; #1;
      check("stall_ready_in", 512'(req_ready_in), 512'(0));
      cycle();
    end
    idle(); cycle();
    check("stall_delivered_once", 512'(req_valid_out), 512'(0));
    idle(); cycle();

    // Response routing to requester 1 and its credit return.
    read_burst(TEX_REQ_IDX, 16);
    idle(); req_valid_in[TEX_REQ_IDX] = 1'b1;
    rsp_valid_in = 1'b1; rsp_tag_in = {8'hA5, 2'd1}; rsp_ready_out = 3'b010; #1;
    check("route_valid", 512'(rsp_valid_out), 512'(3'b010));
    check("route_tag", 512'(rsp_tag_out), 512'(8'hA5));
    check("route_ready", 512'(rsp_ready_in), 512'(1));
    cycle();
    idle(); req_valid_in[TEX_REQ_IDX] = 1'b1; #1;
    check("tex_credit_returned", 512'(req_ready_in[TEX_REQ_IDX]), 512'(1));
    cycle();

    // Out-of-range select.
    idle(); rsp_valid_in = 1'b1; rsp_tag_in = {8'h5A, 2'd3}; rsp_ready_out = '0; #1;
    check("bad_sel_ready", 512'(rsp_ready_in), 512'(1));
    check("bad_sel_valid", 512'(rsp_valid_out), 512'(0));
    cycle();
    check("sel_err_pulse", 512'(sel_err), 512'(1));
    idle(); cycle();
    check("sel_err_clear", 512'(sel_err), 512'(0));

    // Reset with a buffered request and 5 credits in use.
    idle(); reset = 1'b1; cycle();
    read_burst(LSU_REQ_IDX, 5);
    check("pre_reset_valid", 512'(req_valid_out), 512'(1));
    idle(); reset = 1'b1; req_ready_out = 1'b0; cycle();
    check("reset_drops_req", 512'(req_valid_out), 512'(0));
    idle(); req_valid_in = 3'b011; req_rw_in = 3'b011; #1;
    check("reset_ptr_zero", 512'(req_ready_in), 512'(3'b001));
    cycle();
    read_burst(LSU_REQ_IDX, 16);
    idle(); req_valid_in[LSU_REQ_IDX] = 1'b1; #1;
    check("reset_credits_cleared", 512'(req_ready_in[LSU_REQ_IDX]), 512'(0));
    cycle();

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      rand_payload();
      reset         = ($urandom_range(63, 0) == 0);
      req_valid_in  = N'($urandom);
      req_rw_in     = N'($urandom) & N'($urandom);
      req_ready_out = ($urandom_range(3, 0) != 0);
      rsp_valid_in  = $urandom_range(1, 0) == 1;
      rsp_tag_in    = TOW'($urandom);
      rsp_ready_out = N'($urandom) | N'($urandom);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
